// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with counted burst-shift engine (optional Zero flag via SHREG_ZERO_FLAG_EN)
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SinL,
    input  logic             SinR,
    input  logic             Start,
    input  logic [CNT_W-1:0] Cnt,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic             SoutL,
    output logic             SoutR,
    output logic             Busy,
    output logic             Done
`ifdef SHREG_ZERO_FLAG_EN
    ,
    output logic             Zero
`endif
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] burstCnt;
    logic [2:0]       burstMode;
    logic [2:0]       opMode;
    logic [WIDTH-1:0] opResult;
    logic             startOk;

    assign startOk = Start && (Mode >= 3'b010) && (Mode <= 3'b110);
    assign opMode  = (state == BURST) ? burstMode : Mode;

    // next Q for the selected operation; D only reaches the result on load
    always_comb begin
        opResult = Q;
        case (opMode)
            3'b001:  opResult = D;
            3'b010:  opResult = {Q[WIDTH-2:0], SinR};
            3'b011:  opResult = {SinL, Q[WIDTH-1:1]};
            3'b100:  opResult = {Q[WIDTH-2:0], Q[WIDTH-1]};
            3'b101:  opResult = {Q[0], Q[WIDTH-1:1]};
            3'b110:  opResult = {Q[WIDTH-1], Q[WIDTH-1:1]};
            3'b111:  opResult = '0;
            default: opResult = Q;
        endcase
    end

    // register, burst counter and IDLE/BURST/DONE sequencing
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Q         <= '0;
            state     <= IDLE;
            burstCnt  <= '0;
            burstMode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startOk) begin
                        burstMode <= Mode;
                        burstCnt  <= Cnt;
                        state     <= (Cnt != '0) ? BURST : DONE;
                    end else if (En) begin
                        Q <= opResult;
                    end
                end
                BURST: begin
                    Q        <= opResult;
                    burstCnt <= burstCnt - 1'b1;
                    if (burstCnt == CNT_W'(1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign notQ  = ~Q;
    assign SoutL = Q[WIDTH-1];
    assign SoutR = Q[0];
    assign Busy  = (state == BURST);
    assign Done  = (state == DONE);
`ifdef SHREG_ZERO_FLAG_EN
    assign Zero  = (Q == '0);
`endif
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;
    logic       Clk = 0;
    logic       Rst = 0;
    logic       En = 0;
    logic [2:0] Mode = 0;
    logic [7:0] D = 0;
    logic       SinL = 0;
    logic       SinR = 0;
    logic       Start = 0;
    logic [3:0] Cnt = 0;
    logic [7:0] Q;
    logic [7:0] notQ;
    logic       SoutL;
    logic       SoutR;
    logic       Busy;
    logic       Done;
`ifdef SHREG_ZERO_FLAG_EN
    logic       Zero;
`endif
    int tests = 0;
    int fails = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .D(D), .SinL(SinL), .SinR(SinR),
        .Start(Start), .Cnt(Cnt), .Q(Q), .notQ(notQ), .SoutL(SoutL), .SoutR(SoutR),
        .Busy(Busy), .Done(Done)
`ifdef SHREG_ZERO_FLAG_EN
        , .Zero(Zero)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        Start = 0; En = 1; Mode = 3'b001; D = v;
        tick;
        En = 0; Mode = 3'b000;
    endtask

    task automatic test_reset;
        Rst = 1; D = 8'hFF; En = 1; Mode = 3'b001;
        tick;
        Rst = 0; En = 0; Mode = 0;
        tests++;
        if (Q !== 8'h00 || notQ !== 8'hFF || Busy !== 1'b0 || Done !== 1'b0) begin
            fails++;
            $display("FAIL reset: Q=%h notQ=%h Busy=%b Done=%b, want 00 FF 0 0", Q, notQ, Busy, Done);
        end
`ifdef SHREG_ZERO_FLAG_EN
        tests++;
        if (Zero !== 1'b1) begin fails++; $display("FAIL reset_zero: Zero=%b want 1", Zero); end
`endif
    endtask

    task automatic test_single_ops;
        load(8'hA5);
        tests++;
        if (Q !== 8'hA5) begin fails++; $display("FAIL load: Q=%h want a5", Q); end
        En = 1; Mode = 3'b010; SinR = 1;
        tick;
        tests++;
        if (Q !== 8'h4B || SoutL !== 1'b0 || SoutR !== 1'b1 || notQ !== 8'hB4) begin
            fails++;
            $display("FAIL shl: Q=%h SoutL=%b SoutR=%b notQ=%h, want 4b 0 1 b4", Q, SoutL, SoutR, notQ);
        end
        Mode = 3'b101;
        tick;
        tests++;
        if (Q !== 8'hA5) begin fails++; $display("FAIL ror: Q=%h want a5", Q); end
        En = 0; Mode = 3'b111;
        tick;
        tests++;
        if (Q !== 8'hA5) begin fails++; $display("FAIL en_low_hold: Q=%h want a5", Q); end
        En = 1;
        tick;
        tests++;
        if (Q !== 8'h00) begin fails++; $display("FAIL clear: Q=%h want 00", Q); end
        load(8'h81);
        En = 1; Mode = 3'b100;
        tick;
        tests++;
        if (Q !== 8'h03) begin fails++; $display("FAIL rol: Q=%h want 03", Q); end
        Mode = 3'b011; SinL = 1;
        tick;
        tests++;
        if (Q !== 8'h81) begin fails++; $display("FAIL shr: Q=%h want 81", Q); end
        Mode = 3'b110;
        tick;
        tests++;
        if (Q !== 8'hC0) begin fails++; $display("FAIL asr: Q=%h want c0", Q); end
        Mode = 3'b000; D = 8'h11;
        tick;
        tests++;
        if (Q !== 8'hC0) begin fails++; $display("FAIL hold: Q=%h want c0", Q); end
        En = 0; SinL = 0; SinR = 0;
    endtask

    task automatic test_burst_rol;
        load(8'h81);
        Start = 1; Mode = 3'b100; Cnt = 3; En = 0;
        tick;
        tests++;
        if (Q !== 8'h81 || Busy !== 1'b1) begin fails++; $display("FAIL burst_start: Q=%h Busy=%b want 81 1", Q, Busy); end
        Start = 0; Mode = 3'b001; D = 8'h00; En = 1; Cnt = 9;
        tick;
        tests++;
        if (Q !== 8'h03 || Busy !== 1'b1) begin fails++; $display("FAIL burst_1: Q=%h Busy=%b want 03 1", Q, Busy); end
        tick;
        tests++;
        if (Q !== 8'h06 || Busy !== 1'b1) begin fails++; $display("FAIL burst_2: Q=%h Busy=%b want 06 1", Q, Busy); end
        tick;
        tests++;
        if (Q !== 8'h0C || Busy !== 1'b0 || Done !== 1'b1) begin
            fails++;
            $display("FAIL burst_done: Q=%h Busy=%b Done=%b want 0c 0 1", Q, Busy, Done);
        end
        Start = 1; Mode = 3'b100; Cnt = 2; En = 1;
        tick;
        Start = 0; En = 0; Mode = 0;
        tests++;
        if (Q !== 8'h0C || Busy !== 1'b0 || Done !== 1'b0) begin
            fails++;
            $display("FAIL done_ignores_start: Q=%h Busy=%b Done=%b want 0c 0 0", Q, Busy, Done);
        end
    endtask

    task automatic test_burst_saturate(input logic [2:0] m, input logic [7:0] init, input logic [7:0] exp);
        int busyCycles = 0;
        int i = 0;
        load(init);
        Start = 1; Mode = m; Cnt = 15; SinL = 0;
        tick;
        Start = 0; Mode = 0;
        while (!Done && i < 40) begin
            if (Busy) busyCycles++;
            tick;
            i++;
        end
        tests++;
        if (Done !== 1'b1 || Q !== exp) begin
            fails++;
            $display("FAIL burst_sat_mode%0d: Done=%b Q=%h want 1 %h", m, Done, Q, exp);
        end
        tests++;
        if (busyCycles != 15) begin fails++; $display("FAIL burst_sat_busy_mode%0d: busy=%0d want 15", m, busyCycles); end
        tick;
    endtask

    task automatic test_rotate_wrap;
        load(8'h96);
        Start = 1; Mode = 3'b101; Cnt = 9;
        tick;
        Start = 0; Mode = 0;
        for (int i = 0; i < 9; i++) tick;
        tests++;
        if (Done !== 1'b1 || Q !== 8'h4B) begin fails++; $display("FAIL ror_wrap: Done=%b Q=%h want 1 4b", Done, Q); end
        tick;
    endtask

    task automatic test_cnt_zero;
        load(8'h5A);
        Start = 1; Mode = 3'b010; Cnt = 0; SinR = 1;
        tick;
        Start = 0; Mode = 0;
        tests++;
        if (Q !== 8'h5A || Busy !== 1'b0 || Done !== 1'b1) begin
            fails++;
            $display("FAIL cnt_zero: Q=%h Busy=%b Done=%b want 5a 0 1", Q, Busy, Done);
        end
        tick;
        tests++;
        if (Done !== 1'b0 || Q !== 8'h5A) begin fails++; $display("FAIL cnt_zero_idle: Done=%b Q=%h want 0 5a", Done, Q); end
        Start = 1; Mode = 3'b001; En = 1; D = 8'h3C; Cnt = 4;
        tick;
        Start = 0; En = 0; Mode = 0;
        tests++;
        if (Q !== 8'h3C || Busy !== 1'b0 || Done !== 1'b0) begin
            fails++;
            $display("FAIL start_load_ignored: Q=%h Busy=%b Done=%b want 3c 0 0", Q, Busy, Done);
        end
        SinR = 0;
    endtask

    task automatic test_abort;
        logic sawDone = 0;
        load(8'hF0);
        Start = 1; Mode = 3'b010; Cnt = 5; SinR = 0;
        tick;
        Start = 0; Mode = 0;
        tick;
        tick;
        tests++;
        if (Q !== 8'hC0 || Busy !== 1'b1) begin fails++; $display("FAIL abort_pre: Q=%h Busy=%b want c0 1", Q, Busy); end
        Rst = 1;
        tick;
        Rst = 0;
        tests++;
        if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: Q=%h Busy=%b Done=%b want 00 0 0", Q, Busy, Done);
        end
        for (int i = 0; i < 6; i++) begin
            tick;
            if (Done || Busy) sawDone = 1;
        end
        tests++;
        if (sawDone !== 1'b0 || Q !== 8'h00) begin fails++; $display("FAIL abort_no_done: sawDone=%b Q=%h want 0 00", sawDone, Q); end
`ifdef SHREG_ZERO_FLAG_EN
        tests++;
        if (Zero !== 1'b1) begin fails++; $display("FAIL zero_after_reset: Zero=%b want 1", Zero); end
        load(8'h01);
        tests++;
        if (Zero !== 1'b0) begin fails++; $display("FAIL zero_after_load: Zero=%b want 0", Zero); end
`endif
    endtask

    initial begin
        test_reset;
        test_single_ops;
        test_burst_rol;
        test_burst_saturate(3'b110, 8'h80, 8'hFF);
        test_burst_saturate(3'b011, 8'h80, 8'h00);
        test_rotate_wrap;
        test_cnt_zero;
        test_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
